// File: rtl/tictactoe_move_ctrl_if.sv
// Bundle of player controls, checker feedback and board/status outputs
// between the move controller and its environment.
interface tictactoe_move_ctrl_if #(
    parameter int SCORE_W = 4
);
    logic               btn_move;
    logic [3:0]         sw_addr;
    logic               new_game;
    logic               win_x;
    logic               win_o;
    logic               full;
    logic               error;
    logic [0:8]         x;
    logic [0:8]         o;
    logic               turn;
    logic               move_ack;
    logic               move_reject;
    logic               game_over;
    logic               fault;
    logic [SCORE_W-1:0] score_x;
    logic [SCORE_W-1:0] score_o;

    modport master (
        output btn_move, sw_addr, new_game, win_x, win_o, full, error,
        input  x, o, turn, move_ack, move_reject, game_over, fault, score_x, score_o
    );

    modport slave (
        input  btn_move, sw_addr, new_game, win_x, win_o, full, error,
        output x, o, turn, move_ack, move_reject, game_over, fault, score_x, score_o
    );
endinterface

// File: rtl/tictactoe_move_ctrl.sv
// Move controller: debounces the move button, writes legal moves into the X/O
// boards, reads back the checker verdict and keeps saturating win scores.
module tictactoe_move_ctrl #(
    parameter int FIRST_PLAYER    = 0,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCORE_W         = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tictactoe_move_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic               FIRST_P   = 1'(FIRST_PLAYER);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        OVER  = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [1:0]         sync_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               deb_r, deb_d_r;
    logic               move_req_s;
    logic [0:8]         sel_s;
    logic               legal_s;
    logic [0:8]         x_r, x_s, o_r, o_s;
    logic               turn_r, turn_s;
    logic               ack_r, ack_s, rej_r, rej_s;
    logic               fault_r, fault_s;
    logic               game_over_r;
    logic [SCORE_W-1:0] score_x_r, score_x_s, score_o_r, score_o_s;

    // Synchronizer and debounce counter producing a clean button level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r  <= 2'b00;
            cnt_r   <= '0;
            deb_r   <= 1'b0;
            deb_d_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[0], bus.btn_move};
            deb_d_r <= deb_r;
            if (!sync_r[1]) begin
                cnt_r <= '0;
                deb_r <= 1'b0;
            end else if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_W'(1);
                deb_r <= (cnt_r == CNT_MAX - CNT_W'(1));
            end else begin
                deb_r <= 1'b1;
            end
        end
    end

    assign move_req_s = deb_r & ~deb_d_r;

    // Cell decode and legality of the addressed cell.
    always_comb begin
        sel_s = 9'b0;
        for (int i = 0; i < 9; i++) begin
            sel_s[i] = (bus.sw_addr == 4'(i));
        end
        legal_s = (bus.sw_addr <= 4'd8) && ((sel_s & (x_r | o_r)) == 9'b0);
    end

    // Next-state logic for game flow, boards, pulses and scores.
    always_comb begin
        state_s   = state_r;
        x_s       = x_r;
        o_s       = o_r;
        turn_s    = turn_r;
        ack_s     = 1'b0;
        rej_s     = 1'b0;
        fault_s   = fault_r;
        score_x_s = score_x_r;
        score_o_s = score_o_r;
        if (bus.new_game) begin
            state_s = PLAY;
            x_s     = 9'b0;
            o_s     = 9'b0;
            turn_s  = FIRST_P;
            fault_s = 1'b0;
        end else begin
            case (state_r)
                PLAY: begin
                    if (move_req_s && legal_s) begin
                        if (turn_r) begin
                            o_s = o_r | sel_s;
                        end else begin
                            x_s = x_r | sel_s;
                        end
                        ack_s   = 1'b1;
                        state_s = CHECK;
                    end else if (move_req_s) begin
                        rej_s = 1'b1;
                    end else begin
                        state_s = PLAY;
                    end
                end
                // Requests during the verdict cycle are dropped on purpose.
                CHECK: begin
                    if (bus.error) begin
                        fault_s = 1'b1;
                        state_s = OVER;
                    end else if (bus.win_x) begin
                        if (score_x_r != SCORE_MAX) begin
                            score_x_s = score_x_r + SCORE_W'(1);
                        end else begin
                            score_x_s = score_x_r;
                        end
                        state_s = OVER;
                    end else if (bus.win_o) begin
                        if (score_o_r != SCORE_MAX) begin
                            score_o_s = score_o_r + SCORE_W'(1);
                        end else begin
                            score_o_s = score_o_r;
                        end
                        state_s = OVER;
                    end else if (bus.full) begin
                        state_s = OVER;
                    end else begin
                        turn_s  = ~turn_r;
                        state_s = PLAY;
                    end
                end
                OVER: begin
                    if (move_req_s) begin
                        rej_s = 1'b1;
                    end else begin
                        rej_s = 1'b0;
                    end
                end
                default: begin
                    state_s = PLAY;
                end
            endcase
        end
    end

    // Game state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= PLAY;
            x_r         <= 9'b0;
            o_r         <= 9'b0;
            turn_r      <= FIRST_P;
            ack_r       <= 1'b0;
            rej_r       <= 1'b0;
            fault_r     <= 1'b0;
            game_over_r <= 1'b0;
            score_x_r   <= '0;
            score_o_r   <= '0;
        end else begin
            state_r     <= state_s;
            x_r         <= x_s;
            o_r         <= o_s;
            turn_r      <= turn_s;
            ack_r       <= ack_s;
            rej_r       <= rej_s;
            fault_r     <= fault_s;
            game_over_r <= (state_s == OVER);
            score_x_r   <= score_x_s;
            score_o_r   <= score_o_s;
        end
    end

    assign bus.x           = x_r;
    assign bus.o           = o_r;
    assign bus.turn        = turn_r;
    assign bus.move_ack    = ack_r;
    assign bus.move_reject = rej_r;
    assign bus.game_over   = game_over_r;
    assign bus.fault       = fault_r;
    assign bus.score_x     = score_x_r;
    assign bus.score_o     = score_o_r;
endmodule

// File: tb/tb_tictactoe_move_ctrl.sv
// Scoreboard bench for tictactoe_move_ctrl with a behavioural result checker
// closing the loop from the boards back to win/full/error.
module tb_tictactoe_move_ctrl;
    localparam int D  = 4;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic force_err = 1'b0;
    always #5 clk = ~clk;

    tictactoe_move_ctrl_if #(.SCORE_W(SW)) bus ();

    tictactoe_move_ctrl #(
        .FIRST_PLAYER(0), .DEBOUNCE_CYCLES(D), .SCORE_W(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    function automatic logic has_line(input logic [0:8] b);
        return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
               (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    // Behavioural result checker fed from the registered boards.
    always_comb begin
        bus.win_x = has_line(bus.x);
        bus.win_o = has_line(bus.o);
        bus.full  = &(bus.x | bus.o);
        bus.error = force_err;
    end

    typedef struct packed {
        logic       ack;
        logic [0:8] x;
        logic [0:8] o;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [0:8] mx, mo;
    logic       mturn, mover, mfault;
    int         msx, mso;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop one expected pulse per ack/reject seen.
    always @(negedge clk) begin
        if (rst_n && (bus.move_ack || bus.move_reject)) begin
            if (sb.size() == 0) begin
                check_val("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_val("pulse_is_ack", 32'(bus.move_ack), 32'(mon_e.ack));
                check_val("pulse_both", 32'(bus.move_ack & bus.move_reject), 32'd0);
                check_val("pulse_x", 32'(bus.x), 32'(mon_e.x));
                check_val("pulse_o", 32'(bus.o), 32'(mon_e.o));
            end
        end
    end

    task automatic model_clear_board();
        mx = 9'b0; mo = 9'b0; mturn = 1'b0; mover = 1'b0; mfault = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check_val({tag, "_x"},     32'(bus.x),         32'(mx));
        check_val({tag, "_o"},     32'(bus.o),         32'(mo));
        check_val({tag, "_turn"},  32'(bus.turn),      32'(mturn));
        check_val({tag, "_over"},  32'(bus.game_over), 32'(mover));
        check_val({tag, "_fault"}, 32'(bus.fault),     32'(mfault));
        check_val({tag, "_sx"},    32'(bus.score_x),   32'(msx));
        check_val({tag, "_so"},    32'(bus.score_o),   32'(mso));
        check_val({tag, "_sbq"},   32'(sb.size()),     32'd0);
    endtask

    task automatic do_move(input int a, input int hold);
        logic [0:8] sel;
        sel = 9'b0;
        if (a <= 8) sel[a] = 1'b1;
        if (mover || a > 8 || ((sel & (mx | mo)) != 9'b0)) begin
            sb.push_back('{1'b0, mx, mo});
        end else begin
            if (mturn) mo = mo | sel;
            else       mx = mx | sel;
            sb.push_back('{1'b1, mx, mo});
            if (force_err) begin
                mfault = 1'b1; mover = 1'b1;
            end else if (has_line(mx)) begin
                mover = 1'b1; if (msx < 15) msx++;
            end else if (has_line(mo)) begin
                mover = 1'b1; if (mso < 15) mso++;
            end else if (&(mx | mo)) begin
                mover = 1'b1;
            end else begin
                mturn = ~mturn;
            end
        end
        bus.sw_addr  = 4'(a);
        bus.btn_move = 1'b1;
        repeat (hold) @(posedge clk);
        #1 bus.btn_move = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic do_new_game();
        model_clear_board();
        bus.new_game = 1'b1;
        @(posedge clk);
        #1 bus.new_game = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic play_x_win();
        do_move(0, 6); do_move(3, 6); do_move(1, 6); do_move(4, 6); do_move(2, 6);
    endtask

    initial begin
        bus.btn_move = 1'b0;
        bus.sw_addr  = 4'd0;
        bus.new_game = 1'b0;
        model_clear_board();
        msx = 0; mso = 0;
        repeat (3) @(posedge clk);
        #1 check_state("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Long hold on centre: exactly one ack.
        do_move(4, 14);
        check_state("t1_centre");

        // Press shorter than the debounce window is ignored.
        bus.sw_addr = 4'd0; bus.btn_move = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.btn_move = 1'b0;
        repeat (8) @(posedge clk);
        #1 check_state("t2_glitch");

        do_move(4, 6);
        do_move(9, 6);
        check_state("t3_illegal");

        do_new_game();
        play_x_win();
        check_state("t4_xwin");
        do_move(5, 6);
        check_state("t4_after_over");

        do_new_game();
        do_move(0, 6); do_move(1, 6); do_move(2, 6); do_move(4, 6); do_move(3, 6);
        do_move(5, 6); do_move(7, 6); do_move(6, 6); do_move(8, 6);
        check_state("t5_draw");
        do_new_game();
        check_state("t5_new_game");

        force_err = 1'b1;
        do_move(0, 6);
        check_state("t6_error");
        force_err = 1'b0;
        do_new_game();
        check_state("t6_fault_clear");

        while (msx < 15) begin
            do_new_game();
            play_x_win();
        end
        check_state("t6_score15");
        do_new_game();
        play_x_win();
        check_state("t6_saturate");

        // Reset while a press is being debounced, mid-game.
        do_new_game();
        do_move(0, 6);
        bus.sw_addr = 4'd1; bus.btn_move = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        model_clear_board();
        msx = 0; mso = 0;
        check_state("t6_reset_mid");
        bus.btn_move = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1 check_state("t6_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
